sampleq_arbiter: RTL and testbench

Round-robin scheduler that shares one downstream sample stream between up to 8 `sampleq` instances. Each grant serves one bounded burst: a header word with the source index and word count, then exactly that many sample words pulled from the granted queue. The block paces its pulls to respect the queue's registered read data and registered availability flag. It sits between the per-channel sample queues and the single host-facing stream/USB packetizer.

---
 rtl/sampleq_arbiter.sv | 226 ++++++++++++++++++++++
 tb/tb_sampleq_arbiter.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sampleq_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : sampleq_arbiter
//  Purpose  : Round-robin scheduler sharing one downstream sample stream
//             between up to 8 sampleq sources. Each grant emits a header
//             word {A5, src, count} followed by exactly `count` words pulled
//             from the granted queue. Pulls are paced so that the queue's
//             registered data/avail outputs have settled before reuse. If the
//             source runs dry mid-burst, the burst is padded with FFFF_FFFF.
//  Ports    : clk, rst          - clock, synchronous active-high reset
//             src_data/count/avail/pull/enable - per-source queue interface
//             out_data/out_avail/out_pull      - downstream stream
//             err_underrun/err_clear           - sticky underrun flag
//  Revision : 1.0 - initial release
// ============================================================================
module sampleq_arbiter #(
    parameter int NUM_SRC = 2,
    parameter int SETTLE  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [32*NUM_SRC-1:0]  src_data,
    input  logic [8*NUM_SRC-1:0]   src_count,
    input  logic [NUM_SRC-1:0]     src_avail,
    output logic [NUM_SRC-1:0]     src_pull,
    input  logic [NUM_SRC-1:0]     src_enable,
    output logic [31:0]            out_data,
    output logic                   out_avail,
    input  logic                   out_pull,
    output logic                   err_underrun,
    input  logic                   err_clear
);

    localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int NPAD  = 1 << IDX_W;
    localparam int CNT_W = $clog2(SETTLE + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_HEADER = 3'd1,
        S_DATA   = 3'd2,
        S_SETTLE = 3'd3,
        S_PAD    = 3'd4
    } state_t;

    state_t             r_state, w_state_nx;
    logic [IDX_W-1:0]   r_rr_ptr, w_rr_nx;
    logic [IDX_W-1:0]   r_grant, w_grant_nx;
    logic [7:0]         r_rem, w_rem_nx;
    logic [CNT_W-1:0]   r_settle, w_settle_nx;
    logic               w_err_set;
    logic               w_pull_any;

    // Per-source views, padded to a power of two so any index is in range.
    logic [31:0]        w_data  [NPAD];
    logic [7:0]         w_count [NPAD];
    logic [NPAD-1:0]    w_avail;
    logic [NPAD-1:0]    w_elig;

    for (genvar gi = 0; gi < NPAD; gi++) begin : g_src
        if (gi < NUM_SRC) begin : g_real
            assign w_data[gi]  = src_data[32*gi +: 32];
            assign w_count[gi] = src_count[8*gi +: 8];
            assign w_avail[gi] = src_avail[gi];
            assign w_elig[gi]  = src_avail[gi] && src_enable[gi] &&
                                 (src_count[8*gi +: 8] != 8'd0);
        end else begin : g_pad
            assign w_data[gi]  = 32'h0;
            assign w_count[gi] = 8'h0;
            assign w_avail[gi] = 1'b0;
            assign w_elig[gi]  = 1'b0;
        end
    end

    // First eligible source at or after rr_ptr (with wrap). The loop runs
    // from the farthest candidate down so the nearest hit is written last.
    logic               w_hit;
    logic [IDX_W-1:0]   w_hit_idx;
    logic [IDX_W-1:0]   w_cand;

    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = '0;
        w_cand    = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            int j;
            j = int'(r_rr_ptr) + k;
            if (j >= NUM_SRC) begin
                j = j - NUM_SRC;
            end
            w_cand = IDX_W'(j);
            if (w_elig[w_cand]) begin
                w_hit     = 1'b1;
                w_hit_idx = w_cand;
            end
        end
    end

    logic [IDX_W-1:0]   w_grant_inc;
    logic [2:0]         w_grant3;
    logic [31:0]        w_gdata;
    logic               w_gavail;

    assign w_grant_inc = (r_grant == IDX_W'(NUM_SRC - 1)) ? '0 : r_grant + 1'b1;
    assign w_grant3    = 3'(r_grant);
    assign w_gdata     = w_data[r_grant];
    assign w_gavail    = w_avail[r_grant];

    always_comb begin
        w_state_nx  = r_state;
        w_grant_nx  = r_grant;
        w_rem_nx    = r_rem;
        w_settle_nx = r_settle;
        w_rr_nx     = r_rr_ptr;
        w_err_set   = 1'b0;
        w_pull_any  = 1'b0;
        out_avail   = 1'b0;
        out_data    = 32'h0;

        case (r_state)
            S_IDLE: begin
                if (w_hit) begin
                    w_grant_nx = w_hit_idx;
                    w_rem_nx   = w_count[w_hit_idx];
                    w_state_nx = S_HEADER;
                end
            end

            S_HEADER: begin
                out_avail = 1'b1;
                out_data  = {8'hA5, 4'h0, 1'b0, w_grant3, 8'h00, r_rem};
                if (out_pull) begin
                    w_state_nx = S_DATA;
                end
            end

            S_DATA: begin
                out_data  = w_gdata;
                out_avail = w_gavail;
                if (!w_gavail) begin
                    // Source ran dry after it had settled: pad out the burst.
                    w_err_set  = 1'b1;
                    w_state_nx = S_PAD;
                end else if (out_pull) begin
                    w_pull_any  = 1'b1;
                    w_rem_nx    = r_rem - 8'd1;
                    w_settle_nx = CNT_W'(SETTLE);
                    w_state_nx  = S_SETTLE;
                end
            end

            S_SETTLE: begin
                w_settle_nx = r_settle - 1'b1;
                if (r_settle <= CNT_W'(1)) begin
                    if (r_rem == 8'd0) begin
                        w_state_nx = S_IDLE;
                        w_rr_nx    = w_grant_inc;
                    end else begin
                        w_state_nx = S_DATA;
                    end
                end
            end

            S_PAD: begin
                out_avail = 1'b1;
                out_data  = 32'hFFFF_FFFF;
                if (out_pull) begin
                    if (r_rem != 8'd0) begin
                        w_rem_nx = r_rem - 8'd1;
                    end
                    if (r_rem <= 8'd1) begin
                        w_state_nx = S_IDLE;
                        w_rr_nx    = w_grant_inc;
                    end
                end
            end

            default: begin
                w_state_nx = S_IDLE;
            end
        endcase

        // Nothing is offered downstream while reset is being applied.
        if (rst) begin
            out_avail = 1'b0;
        end
    end

    // Pull strobe is combinational and suppressed during reset so a queue
    // never loses a word to a burst that is being abandoned.
    always_comb begin
        src_pull = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            src_pull[k] = w_pull_any && !rst && (r_grant == IDX_W'(k));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_rr_ptr <= '0;
            r_grant  <= '0;
            r_rem    <= 8'd0;
            r_settle <= '0;
        end else begin
            r_state  <= w_state_nx;
            r_rr_ptr <= w_rr_nx;
            r_grant  <= w_grant_nx;
            r_rem    <= w_rem_nx;
            r_settle <= w_settle_nx;
        end
    end

    // Clear wins over a same-cycle set.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_underrun <= 1'b0;
        end else if (err_clear) begin
            err_underrun <= 1'b0;
        end else if (w_err_set) begin
            err_underrun <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sampleq_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sampleq_arbiter
//  Purpose  : Self-checking bench for sampleq_arbiter. Sources are modelled
//             as word queues; expected stream words are queued when stimulus
//             is issued and compared by a monitor on every downstream
//             transfer. Ports: none (top level).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sampleq_arbiter;

    localparam int N      = 3;
    localparam int SETTLE = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic [32*N-1:0]    src_data;
    logic [8*N-1:0]     src_count;
    logic [N-1:0]       src_avail;
    logic [N-1:0]       src_pull;
    logic [N-1:0]       src_enable;
    logic [31:0]        out_data;
    logic               out_avail;
    logic               out_pull;
    logic               err_underrun;
    logic               err_clear;

    sampleq_arbiter #(.NUM_SRC(N), .SETTLE(SETTLE)) dut (
        .clk          (clk),
        .rst          (rst),
        .src_data     (src_data),
        .src_count    (src_count),
        .src_avail    (src_avail),
        .src_pull     (src_pull),
        .src_enable   (src_enable),
        .out_data     (out_data),
        .out_avail    (out_avail),
        .out_pull     (out_pull),
        .err_underrun (err_underrun),
        .err_clear    (err_clear)
    );

    always #5 clk = ~clk;

    typedef logic [31:0] wq_t[$];
    wq_t            sq [N];
    logic [31:0]    exp_q[$];
    logic [N-1:0]   force_low;
    logic [N-1:0]   force_cnt0;
    logic [N-1:0]   pend;
    int             n_err = 0;
    int             n_checks = 0;
    int             m_ptr = 0;
    int             cyc = 0;
    bit             chk_en = 1'b1;
    bit             rand_pull = 1'b0;
    bit             gap_chk = 1'b0;
    bit             track1 = 1'b0;
    int             cnt1 = 0;
    int             np0 = 0;
    int             last0 = 0;
    logic [N-1:0]   prev_pull = '0;
    logic           prev_av = 1'b0;
    logic           prev_op = 1'b0;
    logic           prev_rst = 1'b1;
    logic [31:0]    prev_data = '0;

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    function automatic logic [31:0] hdr(int g, int n);
        return 32'hA500_0000 | (32'(g) << 16) | 32'(n);
    endfunction

    task automatic drive_srcs();
        for (int i = 0; i < N; i++) begin
            int sz;
            sz = sq[i].size();
            src_data[32*i +: 32] = (sz != 0) ? sq[i][0] : 32'h0;
            src_avail[i]         = (sz != 0) && !force_low[i];
            src_count[8*i +: 8]  = force_cnt0[i] ? 8'd0 : ((sz > 255) ? 8'd255 : 8'(sz));
        end
    endtask

    // Reference: round-robin over non-empty enabled queues; each grant
    // drains the whole queue as header + words.
    task automatic plan(logic [N-1:0] en);
        int sz [N];
        for (int i = 0; i < N; i++) sz[i] = sq[i].size();
        for (int b = 0; b < N; b++) begin
            bit found;
            int g;
            found = 1'b0;
            g = 0;
            for (int k = 0; k < N; k++) begin
                int j;
                j = (m_ptr + k) % N;
                if (!found && sz[j] > 0 && en[j]) begin
                    found = 1'b1;
                    g = j;
                end
            end
            if (found) begin
                exp_q.push_back(hdr(g, sz[g]));
                for (int w = 0; w < sz[g]; w++) exp_q.push_back(sq[g][w]);
                sz[g] = 0;
                m_ptr = (g + 1) % N;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(int budget);
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < budget) begin
            @(posedge clk);
            c++;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            n_err++;
            $display("FAIL drain: %0d words outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
        repeat (SETTLE + 3) @(posedge clk);
        #1;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Source model: apply pulls seen in the previous cycle, refresh outputs.
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < N; i++) begin
            if (pend[i] && sq[i].size() != 0) void'(sq[i].pop_front());
        end
        pend = '0;
        drive_srcs();
    end

    always @(posedge clk) begin
        #1;
        if (rand_pull) out_pull = ($urandom_range(0, 3) != 0);
    end

    // Monitor: scoreboard + handshake rules.
    always @(negedge clk) begin
        if (chk_en && !rst && out_avail && out_pull) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL stream: got unexpected word %h, expected none", out_data);
            end else begin
                check("stream", out_data, exp_q.pop_front());
            end
        end
        check("pull_onehot", 32'($countones(src_pull) <= 1), 32'd1);
        check("pull_back2back", 32'((prev_pull != '0) && (src_pull != '0)), 32'd0);
        if (!rst && !prev_rst && prev_av && !prev_op) begin
            check("hold_avail", 32'(out_avail), 32'd1);
            check("hold_data", out_data, prev_data);
        end
        if (src_pull[0]) begin
            if (gap_chk && np0 > 0) check("pull_gap", 32'(cyc - last0), 32'(SETTLE + 1));
            last0 = cyc;
            np0++;
        end
        if (track1 && src_pull[1]) begin
            cnt1++;
            if (cnt1 == 2) force_low[1] = 1'b1;
        end
        pend      = src_pull;
        prev_pull = src_pull;
        prev_av   = out_avail;
        prev_op   = out_pull;
        prev_rst  = rst;
        prev_data = out_data;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int c;
        rst = 1'b1; src_enable = '0; out_pull = 1'b0; err_clear = 1'b0;
        force_low = '0; force_cnt0 = '0; pend = '0;
        src_data = '0; src_count = '0; src_avail = '0;
        drive_srcs();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_avail", 32'(out_avail), 32'd0);
        check("rst_data", out_data, 32'h0);
        check("rst_pull", 32'(src_pull), 32'd0);
        check("rst_err", 32'(err_underrun), 32'd0);

        // Single-source burst with grant latency and pull spacing
        step();
        sq[0] = '{32'h11, 32'h22, 32'h33};
        drive_srcs();
        out_pull = 1'b1; gap_chk = 1'b1; np0 = 0;
        src_enable = 3'b001;
        plan(src_enable);
        @(negedge clk);
        check("lat_idle", 32'(out_avail), 32'd0);
        @(negedge clk);
        check("lat_hdr", 32'(out_avail), 32'd1);
        check("hdr_const", out_data, 32'hA500_0003);
        wait_drain(100);
        check("burst1_pulls", 32'(np0), 32'd3);
        gap_chk = 1'b0;
        src_enable = '0;

        // Round robin between src0/src1, then wrap with only src2
        for (int r = 0; r < 2; r++) begin
            sq[0] = '{32'h100 + 32'(r)};
            sq[1] = '{32'h200 + 32'(r)};
            drive_srcs();
            src_enable = 3'b011;
            plan(src_enable);
            wait_drain(100);
        end
        for (int r = 0; r < 2; r++) begin
            sq[2] = '{32'h300 + 32'(r), 32'h310 + 32'(r)};
            drive_srcs();
            src_enable = 3'b100;
            plan(src_enable);
            wait_drain(100);
        end
        sq[0] = '{32'hA0}; sq[1] = '{32'hA1}; sq[2] = '{32'hA2};
        drive_srcs();
        src_enable = 3'b111;
        plan(src_enable);
        wait_drain(100);
        src_enable = '0;

        // Backpressure in HEADER and in DATA
        sq[0] = '{32'hB0, 32'hB1};
        drive_srcs();
        out_pull = 1'b0;
        src_enable = 3'b001;
        plan(src_enable);
        step();
        repeat (5) begin
            @(negedge clk);
            check("bp_hdr_avail", 32'(out_avail), 32'd1);
            check("bp_hdr_data", out_data, hdr(0, 2));
            check("bp_hdr_pull", 32'(src_pull), 32'd0);
        end
        step();
        out_pull = 1'b1;
        step();
        out_pull = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("bp_dat_avail", 32'(out_avail), 32'd1);
            check("bp_dat_data", out_data, 32'hB0);
            check("bp_dat_pull", 32'(src_pull), 32'd0);
        end
        step();
        out_pull = 1'b1;
        wait_drain(100);
        src_enable = '0;

        // Underrun: src1 count 4 drops avail after 2 pulls
        for (int pass = 0; pass < 2; pass++) begin
            sq[1] = '{32'hC0, 32'hC1, 32'hC2, 32'hC3};
            cnt1 = 0; track1 = 1'b1; force_low = '0;
            drive_srcs();
            err_clear = (pass == 1);
            exp_q.push_back(hdr(1, 4));
            exp_q.push_back(32'hC0);
            exp_q.push_back(32'hC1);
            exp_q.push_back(32'hFFFF_FFFF);
            exp_q.push_back(32'hFFFF_FFFF);
            m_ptr = 2;
            src_enable = 3'b010;
            wait_drain(100);
            src_enable = '0; track1 = 1'b0;
            sq[1].delete(); force_low = '0;
            drive_srcs();
            step();
            if (pass == 0) begin
                check("err_set", 32'(err_underrun), 32'd1);
                repeat (3) step();
                check("err_sticky", 32'(err_underrun), 32'd1);
                err_clear = 1'b1;
                step();
                err_clear = 1'b0;
                @(negedge clk);
                check("err_cleared", 32'(err_underrun), 32'd0);
                step();
            end else begin
                check("err_clear_prio", 32'(err_underrun), 32'd0);
                err_clear = 1'b0;
            end
        end

        // Ineligible sources: zero count, disabled source
        force_cnt0 = 3'b001;
        sq[0] = '{32'hD0};
        sq[1] = '{32'hD1};
        drive_srcs();
        src_enable = 3'b001;
        repeat (8) begin
            @(negedge clk);
            check("inelig_avail", 32'(out_avail), 32'd0);
            check("inelig_pull", 32'(src_pull), 32'd0);
        end
        step();
        src_enable = '0; force_cnt0 = '0;
        sq[0].delete(); sq[1].delete();
        drive_srcs();
        step();

        // Reset during SETTLE of a count-5 burst on src1
        chk_en = 1'b0;
        sq[1] = '{32'hE0, 32'hE1, 32'hE2, 32'hE3, 32'hE4};
        drive_srcs();
        out_pull = 1'b1;
        src_enable = 3'b010;
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!src_pull[1] && c < 50);
        check("rst_saw_pull", 32'(src_pull[1]), 32'd1);
        step();
        rst = 1'b1;
        @(negedge clk);
        check("rstc_pull", 32'(src_pull), 32'd0);
        check("rstc_avail", 32'(out_avail), 32'd0);
        step();
        src_enable = '0;
        sq[1].delete();
        sq[0] = '{32'hF0};
        sq[1] = '{32'hF1};
        drive_srcs();
        exp_q.delete();
        m_ptr = 0;
        src_enable = 3'b011;
        plan(src_enable);
        chk_en = 1'b1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_avail", 32'(out_avail), 32'd0);
        check("post_rst_pull", 32'(src_pull), 32'd0);
        wait_drain(100);
        src_enable = '0;

        // Randomized rounds with random downstream backpressure
        rand_pull = 1'b1;
        for (int r = 0; r < 15; r++) begin
            logic [N-1:0] en;
            for (int i = 0; i < N; i++) begin
                int sz;
                sz = $urandom_range(0, 5);
                sq[i].delete();
                for (int w = 0; w < sz; w++) sq[i].push_back($urandom);
            end
            drive_srcs();
            en = N'($urandom);
            src_enable = en;
            plan(en);
            wait_drain(600);
            src_enable = '0;
            for (int i = 0; i < N; i++) sq[i].delete();
            drive_srcs();
            step();
        end
        rand_pull = 1'b0;
        out_pull = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
